hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 77 +++++++
 tb/tb_hazard_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush and memory-wait freeze control with performance counters
module hazard_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic [4:0]  id_rt,
  input  logic        id_reg2loc,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_write_register,
  input  logic        mem_branch_taken,
  input  logic        mem_wait,
  input  logic        clear_counts,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        pipe_hold,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, FLUSH = 2'd2, FREEZE = 2'd3} state_t;
  state_t cur, nxt;
  logic [4:0] rd2;
  logic hz;
  assign rd2 = id_reg2loc ? id_rt : id_rm;
  assign hz = ex_mem_read && ex_write_register != 5'd31 && (ex_write_register == id_rn || ex_write_register == rd2);
  assign state = cur;
  // state register; reset drops any stall or freeze in progress
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= RUN;
    else cur <= nxt;
  // control outputs and next state; reset forces the free-running defaults
  always_comb begin
    pc_write = 1'b1;
    ifid_write = 1'b1;
    idex_bubble = 1'b0;
    pipe_hold = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    flush_exmem = 1'b0;
    nxt = RUN;
    if (!reset) begin
      if (mem_wait) begin
        pc_write = 1'b0;
        ifid_write = 1'b0;
        pipe_hold = 1'b1;
        nxt = FREEZE;
      end else if (mem_branch_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        flush_exmem = 1'b1;
        nxt = FLUSH;
      end else if (hz && cur != FLUSH) begin
        pc_write = 1'b0;
        ifid_write = 1'b0;
        idex_bubble = 1'b1;
        nxt = LOAD_STALL;
      end
    end
  end
  // saturating event counters; clear wins over increment
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (clear_counts) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (idex_bubble && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      if (flush_idex && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed checks of stall, flush, freeze, counters and reset
module tb_hazard_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rn, id_rm, id_rt, ex_write_register;
  logic id_reg2loc, ex_mem_read, mem_branch_taken, mem_wait, clear_counts;
  logic pc_write, ifid_write, idex_bubble, pipe_hold, flush_ifid, flush_idex, flush_exmem;
  logic [1:0] state;
  logic [15:0] stall_count, flush_count;
  int errors = 0;
  int checks = 0;

  hazard_controller dut (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt),
    .id_reg2loc(id_reg2loc), .ex_mem_read(ex_mem_read), .ex_write_register(ex_write_register),
    .mem_branch_taken(mem_branch_taken), .mem_wait(mem_wait), .clear_counts(clear_counts),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_rn = 5'd0; id_rm = 5'd0; id_rt = 5'd0; ex_write_register = 5'd0;
    id_reg2loc = 1'b0; ex_mem_read = 1'b0; mem_branch_taken = 1'b0; mem_wait = 1'b0; clear_counts = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    mem_wait = 1'b1; mem_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_write_register = 5'd4; id_rn = 5'd4;
    step();
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write got=%b exp=1", pc_write); end
    checks++; if ({ifid_write, idex_bubble, pipe_hold} !== 3'b100) begin errors++; $display("FAIL reset_ctrl got=%b exp=100", {ifid_write, idex_bubble, pipe_hold}); end
    checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b000) begin errors++; $display("FAIL reset_flush got=%b exp=000", {flush_ifid, flush_idex, flush_exmem}); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", stall_count, flush_count); end
    idle();
    reset = 1'b0;
    step();
    checks++; if (state !== 2'd0 || pc_write !== 1'b1) begin errors++; $display("FAIL idle_run got state=%0d pc=%b exp=0/1", state, pc_write); end
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_read = 1'b1; ex_write_register = 5'd3; id_rn = 5'd3;
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin errors++; $display("FAIL lu_ctrl got=%b exp=001", {pc_write, ifid_write, idex_bubble}); end
    checks++; if (pipe_hold !== 1'b0 || flush_idex !== 1'b0) begin errors++; $display("FAIL lu_other got=%b%b exp=00", pipe_hold, flush_idex); end
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lu_state got=%0d exp=1", state); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL lu_second_stall got=%b exp=1", idex_bubble); end
    step();
    checks++; if (stall_count !== 16'd2 || state !== 2'd1) begin errors++; $display("FAIL lu_count2 got=%0d st=%0d exp=2/1", stall_count, state); end
    idle();
    step();
    checks++; if (state !== 2'd0 || stall_count !== 16'd2) begin errors++; $display("FAIL lu_release got st=%0d cnt=%0d exp=0/2", state, stall_count); end
  endtask

  task automatic test_xzr_reg2loc();
    idle();
    ex_mem_read = 1'b1; ex_write_register = 5'd31; id_rn = 5'd31; id_rm = 5'd31; id_rt = 5'd31;
    #1;
    checks++; if (idex_bubble !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL xzr got bub=%b pc=%b exp=0/1", idex_bubble, pc_write); end
    ex_write_register = 5'd7; id_rn = 5'd0; id_rt = 5'd7; id_rm = 5'd2; id_reg2loc = 1'b0;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL reg2loc0 got=%b exp=0", idex_bubble); end
    id_reg2loc = 1'b1;
    #1;
    checks++; if (idex_bubble !== 1'b1 || pc_write !== 1'b0) begin errors++; $display("FAIL reg2loc1 got bub=%b pc=%b exp=1/0", idex_bubble, pc_write); end
    id_reg2loc = 1'b0; id_rm = 5'd7;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL rm_match got=%b exp=1", idex_bubble); end
    ex_mem_read = 1'b0;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL no_load got=%b exp=0", idex_bubble); end
    idle();
  endtask

  task automatic test_branch();
    idle();
    ex_mem_read = 1'b1; ex_write_register = 5'd5; id_rn = 5'd5; mem_branch_taken = 1'b1;
    #1;
    checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b111) begin errors++; $display("FAIL br_flush got=%b exp=111", {flush_ifid, flush_idex, flush_exmem}); end
    checks++; if ({pc_write, ifid_write, idex_bubble, pipe_hold} !== 4'b1100) begin errors++; $display("FAIL br_ctrl got=%b exp=1100", {pc_write, ifid_write, idex_bubble, pipe_hold}); end
    step();
    checks++; if (state !== 2'd2 || flush_count !== 16'd1) begin errors++; $display("FAIL br_state got st=%0d fc=%0d exp=2/1", state, flush_count); end
    mem_branch_taken = 1'b0;
    #1;
    checks++; if (idex_bubble !== 1'b0 || pc_write !== 1'b1 || flush_idex !== 1'b0) begin errors++; $display("FAIL flush_ignores_hz got bub=%b pc=%b fl=%b exp=0/1/0", idex_bubble, pc_write, flush_idex); end
    step();
    checks++; if (state !== 2'd0 || stall_count !== 16'd2 || flush_count !== 16'd1) begin errors++; $display("FAIL br_after got st=%0d sc=%0d fc=%0d exp=0/2/1", state, stall_count, flush_count); end
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL hz_after_flush got=%b exp=1", idex_bubble); end
    idle();
    step();
  endtask

  task automatic test_freeze();
    idle();
    mem_wait = 1'b1; mem_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({pipe_hold, pc_write, ifid_write, idex_bubble} !== 4'b1000 || {flush_ifid, flush_idex, flush_exmem} !== 3'b000) begin errors++; $display("FAIL frz_cycle%0d got hold/pc/if/bub=%b fl=%b exp=1000/000", i, {pipe_hold, pc_write, ifid_write, idex_bubble}, {flush_ifid, flush_idex, flush_exmem}); end
      step();
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL frz_state%0d got=%0d exp=3", i, state); end
    end
    checks++; if (flush_count !== 16'd1) begin errors++; $display("FAIL frz_fcount got=%0d exp=1", flush_count); end
    mem_wait = 1'b0;
    #1;
    checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b111 || pipe_hold !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL frz_release got fl=%b hold=%b pc=%b exp=111/0/1", {flush_ifid, flush_idex, flush_exmem}, pipe_hold, pc_write); end
    step();
    checks++; if (state !== 2'd2 || flush_count !== 16'd2) begin errors++; $display("FAIL frz_to_flush got st=%0d fc=%0d exp=2/2", state, flush_count); end
    idle();
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL frz_back_run got=%0d exp=0", state); end
  endtask

  task automatic test_counters();
    idle();
    clear_counts = 1'b1;
    step();
    checks++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL clr got=%0d/%0d exp=0/0", stall_count, flush_count); end
    clear_counts = 1'b0;
    ex_mem_read = 1'b1; ex_write_register = 5'd9; id_rn = 5'd9;
    for (int i = 0; i < 65537; i++) @(posedge clk);
    #1;
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat got=%h exp=ffff", stall_count); end
    checks++; if (state !== 2'd1 || flush_count !== 16'd0) begin errors++; $display("FAIL sat_state got st=%0d fc=%0d exp=1/0", state, flush_count); end
    clear_counts = 1'b1;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL clr_stall_active got=%b exp=1", idex_bubble); end
    step();
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL clr_override got=%0d exp=0", stall_count); end
    clear_counts = 1'b0;
    step();
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL count_resume got=%0d exp=1", stall_count); end
    idle();
    step();
  endtask

  task automatic test_async_reset();
    idle();
    mem_branch_taken = 1'b1;
    step();
    mem_branch_taken = 1'b0; mem_wait = 1'b1;
    step();
    checks++; if (state !== 2'd3 || flush_count !== 16'd1) begin errors++; $display("FAIL ar_pre got st=%0d fc=%0d exp=3/1", state, flush_count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL ar_async got st=%0d sc=%0d fc=%0d exp=0/0/0", state, stall_count, flush_count); end
    checks++; if (pipe_hold !== 1'b0 || pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL ar_outputs got hold=%b pc=%b if=%b exp=0/1/1", pipe_hold, pc_write, ifid_write); end
    idle();
    #1;
    reset = 1'b0;
    step();
    checks++; if (state !== 2'd0 || pipe_hold !== 1'b0) begin errors++; $display("FAIL ar_no_pending got st=%0d hold=%b exp=0/0", state, pipe_hold); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_xzr_reg2loc();
    test_branch();
    test_freeze();
    test_counters();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
